// File: rtl/fft_pkg.sv
// Shared widths, FSM encoding and saturation helper
// for the radix-2 butterfly MAC driver.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 15;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 33'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -33'sd32768;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_RR = 3'd1,
    LOAD_R = 3'd2,
    MUL_RI = 3'd3,
    LOAD_I = 3'd4,
    FIN    = 3'd5
  } state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] a_r;
    logic signed [DATA_W-1:0] a_i;
    logic signed [DATA_W-1:0] b_r;
    logic signed [DATA_W-1:0] b_i;
    logic signed [DATA_W-1:0] w_r;
    logic signed [DATA_W-1:0] w_i;
  } bfly_op_t;

  function automatic logic signed [DATA_W-1:0] sat16(
    input logic signed [ACC_W-1:0] v
  );
    if (v > SAT_MAX) begin
      sat16 = 16'sh7FFF;
    end else if (v < SAT_MIN) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/q15_mult.sv
// Signed 16x16 -> 32 multiplier shared by every
// product the butterfly needs.
module q15_mult
  import fft_pkg::*;
(
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [PROD_W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/butterfly_mac_driver.sv
// Sequences one butterfly into the external accumulator:
// real load, imag load, then a clear/done strobe.
module butterfly_mac_driver
  import fft_pkg::*;
(
  input  logic                     clk_MAC,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] A_R,
  input  logic signed [DATA_W-1:0] A_I,
  input  logic signed [DATA_W-1:0] B_R,
  input  logic signed [DATA_W-1:0] B_I,
  input  logic signed [DATA_W-1:0] W_R,
  input  logic signed [DATA_W-1:0] W_I,
  output logic signed [DATA_W-1:0] in_A,
  output logic signed [DATA_W-1:0] in_BW,
  output logic                     Ld_R,
  output logic                     Ld_I,
  output logic                     rst_signal,
  output logic                     busy,
  output logic                     done
);

  state_e                   state_q;
  bfly_op_t                 op_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] in_a_q;
  logic signed [DATA_W-1:0] in_bw_q;
  logic                     ld_r_q;
  logic                     ld_i_q;
  logic                     clr_q;
  logic                     busy_q;
  logic                     done_q;

  logic signed [DATA_W-1:0] m_a;
  logic signed [DATA_W-1:0] m_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  sum_re;
  logic signed [ACC_W-1:0]  sum_im;
  logic                     accept;

  always_comb begin
    m_a = '0;
    m_b = '0;
    unique case (state_q)
      MUL_RR: begin
        m_a = op_q.b_r;
        m_b = op_q.w_r;
      end
      LOAD_R: begin
        m_a = op_q.b_i;
        m_b = op_q.w_i;
      end
      MUL_RI: begin
        m_a = op_q.b_r;
        m_b = op_q.w_i;
      end
      LOAD_I: begin
        m_a = op_q.b_i;
        m_b = op_q.w_r;
      end
      default: ;
    endcase
  end

  q15_mult u_mult (
    .a_i (m_a),
    .b_i (m_b),
    .p_o (prod)
  );

  assign prod_x = {prod[PROD_W-1], prod};
  assign sum_re = acc_q - prod_x;
  assign sum_im = acc_q + prod_x;

  // Busy stays up through the done cycle, which is spent in IDLE.
  assign accept = start && !busy_q && (state_q == IDLE);

  always_ff @(posedge clk_MAC) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      in_a_q  <= '0;
      in_bw_q <= '0;
      ld_r_q  <= 1'b0;
      ld_i_q  <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      in_a_q  <= '0;
      in_bw_q <= '0;
      ld_r_q  <= 1'b0;
      ld_i_q  <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= accept || (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= '{A_R, A_I, B_R, B_I, W_R, W_I};
            state_q <= MUL_RR;
          end
        end
        MUL_RR: begin
          acc_q   <= prod_x;
          state_q <= LOAD_R;
        end
        LOAD_R: begin
          in_bw_q <= sat16(sum_re >>> FRAC_W);
          in_a_q  <= op_q.a_r;
          ld_r_q  <= 1'b1;
          state_q <= MUL_RI;
        end
        MUL_RI: begin
          acc_q   <= prod_x;
          state_q <= LOAD_I;
        end
        LOAD_I: begin
          in_bw_q <= sat16(sum_im >>> FRAC_W);
          in_a_q  <= op_q.a_i;
          ld_i_q  <= 1'b1;
          state_q <= FIN;
        end
        FIN: begin
          done_q  <= 1'b1;
          clr_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_A       = in_a_q;
  assign in_BW      = in_bw_q;
  assign Ld_R       = ld_r_q;
  assign Ld_I       = ld_i_q;
  assign rst_signal = clr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_butterfly_mac_driver.sv
// Bench for butterfly_mac_driver: cycle-indexed expectation
// table filled from the arithmetic rules, plus pinned literals.
module tb_butterfly_mac_driver;

  localparam int MAXC = 512;

  logic        clk_MAC = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A_R, A_I, B_R, B_I, W_R, W_I;
  logic [15:0] in_A, in_BW;
  logic        Ld_R, Ld_I, rst_signal, busy, done;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        ldr;
    logic        ldi;
    logic        rs;
    logic        dn;
    logic        bsy;
    logic [15:0] ina;
    logic [15:0] inbw;
  } exp_t;

  exp_t expv [MAXC];

  butterfly_mac_driver dut (
    .clk_MAC    (clk_MAC),
    .rst        (rst),
    .start      (start),
    .A_R        (A_R),
    .A_I        (A_I),
    .B_R        (B_R),
    .B_I        (B_I),
    .W_R        (W_R),
    .W_I        (W_I),
    .in_A       (in_A),
    .in_BW      (in_BW),
    .Ld_R       (Ld_R),
    .Ld_I       (Ld_I),
    .rst_signal (rst_signal),
    .busy       (busy),
    .done       (done)
  );

  initial forever #5 clk_MAC = ~clk_MAC;

  always @(posedge clk_MAC) cyc <= cyc + 1;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, ex);
    end
  endtask

  // Complex product part, Q1.15 floor shift then clamp.
  function automatic logic [15:0] bw(
    input logic [15:0] br, bi, wr, wi,
    input bit imag
  );
    longint pbr, pbi, pwr, pwi, v, s;
    logic [63:0] r;
    pbr = longint'($signed(br));
    pbi = longint'($signed(bi));
    pwr = longint'($signed(wr));
    pwi = longint'($signed(wi));
    v = imag ? (pbr * pwi + pbi * pwr) : (pbr * pwr - pbi * pwi);
    s = v >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    r = s;
    return r[15:0];
  endfunction

  task automatic schedule(int n);
    if (n + 6 >= MAXC) return;
    for (int k = n + 1; k <= n + 6; k++) expv[k].bsy = 1'b1;
    expv[n+3].ldr  = 1'b1;
    expv[n+3].ina  = A_R;
    expv[n+3].inbw = bw(B_R, B_I, W_R, W_I, 1'b0);
    expv[n+5].ldi  = 1'b1;
    expv[n+5].ina  = A_I;
    expv[n+5].inbw = bw(B_R, B_I, W_R, W_I, 1'b1);
    expv[n+6].dn   = 1'b1;
    expv[n+6].rs   = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < MAXC; i++) expv[i] = '{default: '0};
    forever begin
      @(negedge clk_MAC);
      if (cyc >= 1 && cyc < MAXC - 8) begin
        chk("busy", {15'd0, busy}, {15'd0, expv[cyc].bsy});
        chk("Ld_R", {15'd0, Ld_R}, {15'd0, expv[cyc].ldr});
        chk("Ld_I", {15'd0, Ld_I}, {15'd0, expv[cyc].ldi});
        chk("done", {15'd0, done}, {15'd0, expv[cyc].dn});
        chk("rst_signal", {15'd0, rst_signal}, {15'd0, expv[cyc].rs});
        chk("in_A", in_A, expv[cyc].ina);
        chk("in_BW", in_BW, expv[cyc].inbw);
        if (!rst) begin
          for (int k = cyc + 1; k < MAXC; k++) expv[k] = '{default: '0};
        end else if (start && !expv[cyc].bsy) begin
          schedule(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_MAC);
    #1;
  endtask

  task automatic goto(int c);
    while (cyc < c) step();
  endtask

  task automatic at_neg(int c);
    goto(c);
    @(negedge clk_MAC);
    #1;
  endtask

  task automatic ops(logic [15:0] ar, ai, br, bi, wr, wi);
    A_R = ar; A_I = ai; B_R = br; B_I = bi; W_R = wr; W_I = wi;
  endtask

  logic [15:0] tv [4][6];
  int n;

  initial begin
    tv[0] = '{16'h7FFF, 16'h8000, 16'h5A82, 16'hA57E, 16'h5A82, 16'h5A82};
    tv[1] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h0000, 16'h8000, 16'h8000};
    tv[2] = '{16'h1234, 16'h4321, 16'hC000, 16'h2000, 16'h3000, 16'hF000};
    tv[3] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF};

    rst = 1'b0;
    start = 1'b0;
    ops(0, 0, 0, 0, 0, 0);
    goto(3);
    start = 1'b1;
    ops(16'h1000, 16'h0800, 16'h4000, 0, 16'h4000, 0);
    step();
    rst = 1'b1;
    start = 1'b0;
    at_neg(5);
    chk("pin reset busy", {15'd0, busy}, 16'd0);
    at_neg(6);
    chk("pin start-in-reset Ld_R", {15'd0, Ld_R}, 16'd0);

    // basic real product, operands changed after accept
    goto(10);
    n = cyc;
    start = 1'b1;
    ops(16'h1000, 16'h0800, 16'h4000, 0, 16'h4000, 0);
    step();
    start = 1'b0;
    ops(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
    at_neg(n + 1);
    chk("pin busy N+1", {15'd0, busy}, 16'd1);
    at_neg(n + 3);
    chk("pin 020 re in_BW", in_BW, 16'h2000);
    chk("pin 020 re in_A", in_A, 16'h1000);
    chk("pin 020 Ld_R", {15'd0, Ld_R}, 16'd1);
    at_neg(n + 5);
    chk("pin 020 im in_BW", in_BW, 16'h0000);
    chk("pin 020 im in_A", in_A, 16'h0800);
    at_neg(n + 6);
    chk("pin 020 done", {15'd0, done}, 16'd1);
    chk("pin 020 busy N+6", {15'd0, busy}, 16'd1);
    at_neg(n + 7);
    chk("pin 020 busy N+7", {15'd0, busy}, 16'd0);

    // imag by imag
    goto(n + 10);
    n = cyc;
    start = 1'b1;
    ops(0, 0, 0, 16'h4000, 0, 16'h4000);
    step();
    start = 1'b0;
    at_neg(n + 3);
    chk("pin 021 re in_BW", in_BW, 16'hE000);
    at_neg(n + 5);
    chk("pin 021 im in_BW", in_BW, 16'h0000);

    // saturation
    goto(n + 10);
    n = cyc;
    start = 1'b1;
    ops(0, 0, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF);
    step();
    start = 1'b0;
    at_neg(n + 3);
    chk("pin 022 re in_BW", in_BW, 16'h7FFF);
    at_neg(n + 5);
    chk("pin 022 im in_BW", in_BW, 16'h0001);

    // start while busy is dropped
    goto(n + 10);
    n = cyc;
    start = 1'b1;
    ops(16'h1000, 16'h0800, 16'h4000, 0, 16'h4000, 0);
    step();
    start = 1'b0;
    goto(n + 2);
    start = 1'b1;
    ops(0, 0, 0, 16'h4000, 0, 16'h4000);
    step();
    start = 1'b0;
    at_neg(n + 5);
    chk("pin 023 Ld_I in_BW", in_BW, 16'h0000);
    at_neg(n + 6);
    chk("pin 023 done", {15'd0, done}, 16'd1);
    at_neg(n + 9);
    chk("pin 023 no second Ld_R", {15'd0, Ld_R}, 16'd0);

    // reset mid-operation, then restart
    goto(n + 12);
    n = cyc;
    start = 1'b1;
    ops(16'h1000, 16'h0800, 16'h4000, 0, 16'h4000, 0);
    step();
    start = 1'b0;
    goto(n + 4);
    rst = 1'b0;
    step();
    rst = 1'b1;
    at_neg(n + 5);
    chk("pin 024 busy", {15'd0, busy}, 16'd0);
    chk("pin 024 Ld_I", {15'd0, Ld_I}, 16'd0);
    goto(n + 6);
    start = 1'b1;
    at_neg(n + 6);
    chk("pin 024 no done", {15'd0, done}, 16'd0);
    step();
    start = 1'b0;
    at_neg(n + 9);
    chk("pin 024 restart in_BW", in_BW, 16'h2000);
    chk("pin 024 restart Ld_R", {15'd0, Ld_R}, 16'd1);

    // start held high
    goto(n + 16);
    n = cyc;
    start = 1'b1;
    ops(0, 0, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF);
    at_neg(n + 3);
    chk("pin 025 Ld_R N+3", {15'd0, Ld_R}, 16'd1);
    at_neg(n + 6);
    chk("pin 025 done N+6", {15'd0, done}, 16'd1);
    chk("pin 025 rst_signal N+6", {15'd0, rst_signal}, 16'd1);
    at_neg(n + 10);
    chk("pin 025 Ld_R N+10", {15'd0, Ld_R}, 16'd1);
    chk("pin 025 in_BW N+10", in_BW, 16'h7FFF);
    at_neg(n + 13);
    chk("pin 025 done N+13", {15'd0, done}, 16'd1);
    chk("pin 025 rst_signal N+13", {15'd0, rst_signal}, 16'd1);
    goto(n + 14);
    start = 1'b0;

    // further vectors checked by the model only
    for (int v = 0; v < 4; v++) begin
      goto(cyc + 2);
      start = 1'b1;
      ops(tv[v][0], tv[v][1], tv[v][2], tv[v][3], tv[v][4], tv[v][5]);
      step();
      start = 1'b0;
      ops(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h0BAD, 16'hFACE);
      goto(cyc + 7);
    end

    goto(cyc + 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
